// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives the ECP5 PLL RST pin, qualifies LOCK, gates sys_rst.
// Optional saturating lock-loss counter: define PLL_SUPERVISOR_LOSS_CNT_EN.
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int TIMER_W       = 20
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [7:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [2:0] {
        S_PLL_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    localparam logic [TIMER_W-1:0] RST_LAST  = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STAB_LAST = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
    localparam logic [7:0]         RETRY_MAX = 8'(MAX_RETRIES);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TIMER_W-1:0]   r_timer;
    logic [TIMER_W-1:0]   w_timer_nxt;
    logic [7:0]           r_retry;
    logic [7:0]           w_retry_nxt;
    logic [1:0]           r_sync;
    logic                 w_locked_s;
    logic                 r_pll_rst;
    logic                 r_sys_rst;
    logic                 r_ready;
    logic                 r_fault;

    assign w_locked_s = r_sync[1];

    // Two-flop synchronizer for the asynchronous PLL LOCK pin
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], pll_locked};
        end
    end

    // Next-state, timer and retry bookkeeping
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_retry_nxt = r_retry;
        unique case (r_state)
            S_PLL_RESET: begin
                if (r_timer == RST_LAST) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + TIMER_ONE;
                end
            end
            S_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_nxt = S_STABLE;
                    w_timer_nxt = '0;
                end else if (r_timer == LOCK_LAST) begin
                    w_timer_nxt = '0;
                    if (r_retry == RETRY_MAX) begin
                        w_state_nxt = S_FAULT;
                    end else begin
                        w_state_nxt = S_PLL_RESET;
                        w_retry_nxt = r_retry + 8'd1;
                    end
                end else begin
                    w_timer_nxt = r_timer + TIMER_ONE;
                end
            end
            S_STABLE: begin
                if (!w_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_timer_nxt = '0;
                end else if (r_timer == STAB_LAST) begin
                    w_state_nxt = S_RUN;
                    w_timer_nxt = '0;
                    w_retry_nxt = 8'd0;
                end else begin
                    w_timer_nxt = r_timer + TIMER_ONE;
                end
            end
            S_RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt = S_PLL_RESET;
                    w_timer_nxt = '0;
                end
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
            default: begin
                w_state_nxt = S_PLL_RESET;
                w_timer_nxt = '0;
            end
        endcase
    end

    // State register with outputs decoded from the next state
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state   <= S_PLL_RESET;
            r_timer   <= '0;
            r_retry   <= 8'd0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_retry   <= w_retry_nxt;
            r_pll_rst <= (w_state_nxt == S_PLL_RESET) ||
                         (w_state_nxt == S_FAULT);
            r_sys_rst <= (w_state_nxt != S_RUN);
            r_ready   <= (w_state_nxt == S_RUN);
            r_fault   <= (w_state_nxt == S_FAULT);
        end
    end

    assign pll_rst   = r_pll_rst;
    assign sys_rst   = r_sys_rst;
    assign ready     = r_ready;
    assign fault     = r_fault;
    assign retry_cnt = r_retry;

`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
    logic [7:0] r_loss;
    logic       w_loss_evt;

    assign w_loss_evt = (r_state == S_RUN) && !w_locked_s;

    // Saturating count of lock losses observed while running
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_loss <= 8'd0;
        end else if (w_loss_evt && (r_loss != 8'hFF)) begin
            r_loss <= r_loss + 8'd1;
        end
    end

    assign lock_loss_cnt = r_loss;
`else
    assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor: directed scenarios plus random LOCK
// activity, checked every cycle against a phase/duration reference model.
module tb_pll_lock_supervisor;

    localparam int RC = 4;
    localparam int LT = 32;
    localparam int SC = 8;
    localparam int MR = 2;
`ifdef PLL_SUPERVISOR_LOSS_CNT_EN
    localparam int LOSS_EN = 1;
`else
    localparam int LOSS_EN = 0;
`endif

    logic       clkin = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [7:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int checks = 0;
    int failures = 0;

    pll_lock_supervisor #(
        .RST_CYCLES   (RC),
        .LOCK_TIMEOUT (LT),
        .STABLE_CYCLES(SC),
        .MAX_RETRIES  (MR),
        .TIMER_W      (20)
    ) dut (
        .clkin        (clkin),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .fault        (fault),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #20 clkin = ~clkin;

    // Reference model: phase, edges spent in it, and 2-edge-old LOCK view
    typedef enum int {M_RESET, M_WAIT, M_STABLE, M_RUN, M_FAULT} phase_t;
    phase_t ph = M_RESET;
    int     el = 0;
    int     m_retry = 0;
    int     m_loss = 0;
    bit     m_valid = 1'b0;
    bit     hist [2] = '{1'b0, 1'b0};

    always @(posedge clkin) begin
        bit ls;
        ls = hist[1];
        hist[1] = hist[0];
        hist[0] = pll_locked;
        if (rst) begin
            ph = M_RESET; el = 0; m_retry = 0; m_loss = 0;
            hist[0] = 1'b0; hist[1] = 1'b0;
            m_valid = 1'b1;
        end else begin
            el = el + 1;
            case (ph)
                M_RESET:
                    if (el == RC) begin ph = M_WAIT; el = 0; end
                M_WAIT:
                    if (ls) begin
                        ph = M_STABLE; el = 0;
                    end else if (el == LT) begin
                        el = 0;
                        if (m_retry == MR) ph = M_FAULT;
                        else begin m_retry++; ph = M_RESET; end
                    end
                M_STABLE:
                    if (!ls) begin
                        ph = M_WAIT; el = 0;
                    end else if (el == SC) begin
                        ph = M_RUN; el = 0; m_retry = 0;
                    end
                M_RUN:
                    if (!ls) begin
                        if (LOSS_EN != 0 && m_loss < 255) m_loss++;
                        ph = M_RESET; el = 0;
                    end
                default: ;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clkin) begin
        logic [3:0] exp_v;
        logic [3:0] act_v;
        if (m_valid) begin
            exp_v = {(ph == M_RESET || ph == M_FAULT), (ph != M_RUN),
                     (ph == M_RUN), (ph == M_FAULT)};
            act_v = {pll_rst, sys_rst, ready, fault};
            checks++;
            if (act_v !== exp_v || retry_cnt !== 8'(m_retry) ||
                lock_loss_cnt !== 8'(m_loss)) begin
                failures++;
                if (failures < 30)
                    $display("FAIL model_cmp t=%0t actual rst/sys/rdy/flt=%b retry=%0d loss=%0d required %b retry=%0d loss=%0d",
                             $time, act_v, retry_cnt, lock_loss_cnt,
                             exp_v, m_retry, m_loss);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clkin);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        cyc(n);
        rst = 1'b0;
    endtask

    task automatic wait_ready(input string nm, input int budget);
        int k;
        k = 0;
        while (!ready && k < budget) begin cyc(1); k++; end
        chk(nm, int'(ready), 1);
    endtask

    task automatic wait_pll_rst(input string nm, input logic lvl,
                                input int budget, output int k);
        k = 0;
        while (pll_rst !== lvl && k < budget) begin cyc(1); k++; end
        chk(nm, int'(pll_rst), int'(lvl));
    endtask

    task automatic pulse_len(input string nm, input int exp);
        int n;
        n = 0;
        while (pll_rst && n < 20) begin n++; cyc(1); end
        chk(nm, n, exp);
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_pll_rst"}, int'(pll_rst), 1);
        chk({nm, "_sys_rst"}, int'(sys_rst), 1);
        chk({nm, "_ready"}, int'(ready), 0);
        chk({nm, "_fault"}, int'(fault), 0);
        chk({nm, "_retry"}, int'(retry_cnt), 0);
        chk({nm, "_loss"}, int'(lock_loss_cnt), 0);
    endtask

    initial begin
        int k;
        int n;
        int bad;
        int sys_low;
        int extra_rst;
        int total;
        bit prev;

        // Clean lock
        rst = 1'b1;
        pll_locked = 1'b0;
        cyc(3);
        chk_reset_state("reset");
        rst = 1'b0;
        pulse_len("clean_pll_rst_len", RC);
        cyc(6);
        pll_locked = 1'b1;
        k = 0;
        while (!ready && k < 50) begin cyc(1); k++; end
        chk("clean_lock_to_ready", k, 2 + SC + 1);
        chk("clean_sys_rst", int'(sys_rst), 0);
        chk("clean_retry", int'(retry_cnt), 0);

        // Single timeout
        pll_locked = 1'b0;
        do_reset(2);
        wait_pll_rst("to_first_release", 1'b0, 20, k);
        wait_pll_rst("to_second_pulse", 1'b1, 60, k);
        chk("to_wait_len", k, LT);
        chk("to_retry_1", int'(retry_cnt), 1);
        pll_locked = 1'b1;
        pulse_len("to_pulse_len", RC);
        wait_ready("to_ready", 60);
        chk("to_retry_cleared", int'(retry_cnt), 0);

        // Retry exhaustion
        pll_locked = 1'b0;
        do_reset(2);
        n = 1;
        prev = 1'b1;
        k = 0;
        while (!fault && k < 400) begin
            cyc(1);
            k++;
            if (pll_rst && !prev && !fault) n++;
            prev = pll_rst;
        end
        chk("ex_fault", int'(fault), 1);
        chk("ex_pulses", n, MR + 1);
        bad = 0;
        repeat (200) begin
            if (!(fault && pll_rst && sys_rst && !ready)) bad++;
            cyc(1);
        end
        chk("ex_fault_hold_bad", bad, 0);
        chk("ex_retry_held", int'(retry_cnt), MR);
        rst = 1'b1;
        cyc(1);
        chk("ex_fault_cleared", int'(fault), 0);
        rst = 1'b0;

        // Unstable lock: 5 high / 3 low never qualifies nor times out
        wait_pll_rst("un_release", 1'b0, 20, k);
        sys_low = 0;
        extra_rst = 0;
        bad = 0;
        repeat (25) begin
            pll_locked = 1'b1;
            repeat (5) begin
                cyc(1);
                if (!sys_rst) sys_low++;
                if (pll_rst) extra_rst++;
                if (retry_cnt != 8'd0) bad++;
            end
            pll_locked = 1'b0;
            repeat (3) begin
                cyc(1);
                if (!sys_rst) sys_low++;
                if (pll_rst) extra_rst++;
                if (retry_cnt != 8'd0) bad++;
            end
        end
        chk("un_sys_rst_low", sys_low, 0);
        chk("un_pll_rst_pulses", extra_rst, 0);
        chk("un_retry_changed", bad, 0);
        wait_pll_rst("un_timeout_pulse", 1'b1, 45, k);
        chk("un_retry_1", int'(retry_cnt), 1);

        // Loss in RUN
        pll_locked = 1'b1;
        do_reset(2);
        wait_ready("loss_first_run", 100);
        pll_locked = 1'b0;
        k = 0;
        while (!sys_rst && k < 10) begin
            cyc(1);
            k++;
            if (k == 2) pll_locked = 1'b1;
        end
        pll_locked = 1'b1;
        chk("loss_latency", k, 3);
        chk("loss_cnt_1", int'(lock_loss_cnt), LOSS_EN);
        pulse_len("loss_pulse_len", RC);
        wait_ready("loss_rerun", 60);
        bad = 0;
        for (int i = 0; i < 299; i++) begin
            pll_locked = 1'b0;
            cyc(2);
            pll_locked = 1'b1;
            cyc(2);
            k = 0;
            while (!ready && k < 60) begin cyc(1); k++; end
            if (!ready) bad++;
        end
        chk("loss_rerun_timeouts", bad, 0);
        chk("loss_cnt_sat", int'(lock_loss_cnt), 255 * LOSS_EN);

        // Mid-sequence reset during RUN
        rst = 1'b1;
        cyc(1);
        chk_reset_state("midrun");
        rst = 1'b0;
        wait_ready("midrun_restart", 60);

        // Mid-sequence reset during STABLE with a retry pending
        pll_locked = 1'b0;
        do_reset(1);
        wait_pll_rst("midst_release", 1'b0, 20, k);
        wait_pll_rst("midst_retry", 1'b1, 60, k);
        pll_locked = 1'b1;
        wait_pll_rst("midst_release2", 1'b0, 20, k);
        cyc(4);
        chk("midst_in_stable", int'(!pll_rst && sys_rst), 1);
        chk("midst_retry_1", int'(retry_cnt), 1);
        rst = 1'b1;
        cyc(1);
        chk_reset_state("midstable");
        rst = 1'b0;
        wait_ready("midst_restart", 60);

        // Random LOCK activity with occasional resets
        total = 0;
        while (total < 5000) begin
            pll_locked = 1'($urandom_range(0, 1));
            n = $urandom_range(0, 3) == 0 ? $urandom_range(1, 4)
                                         : $urandom_range(1, 45);
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1;
                cyc(1);
                rst = 1'b0;
                total++;
            end
            cyc(n);
            total += n;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
